// File: rtl/regfile_access_seq_pkg.sv
// Shared definitions for the register-file access sequencer: per-cycle op
// encoding and default width constants.
package regfile_access_seq_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 32;
  localparam int unsigned ADDR_WIDTH_DEF   = 5;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_INIT  = 2'd3
  } op_e;

endpackage

// File: rtl/regfile_wbuf.sv
// One-entry write buffer with per-port read-forwarding compare.
module regfile_wbuf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  drain,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  input  logic [DATA_WIDTH-1:0] rf_data1,
  input  logic [DATA_WIDTH-1:0] rf_data2,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] fwd_data1_c,
  output logic [DATA_WIDTH-1:0] fwd_data2_c
);

  // A load in the draining cycle refills the entry with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  always_comb begin
    fwd_data1_c = (valid && (rd_addr1 == addr)) ? data : rf_data1;
    fwd_data2_c = (valid && (rd_addr2 == addr)) ? data : rf_data2;
  end

endmodule

// File: rtl/regfile_access_seq.sv
// Register-file access sequencer: arbitrates unbuffered reads against a
// buffered write, with starvation bound, forwarding and post-reset clear.
module regfile_access_seq
  import regfile_access_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned INIT_CLEAR   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RD_VALID,
  output logic                  RD_READY,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR1,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR2,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_DATA1,
  output logic [DATA_WIDTH-1:0] RSP_DATA2,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  op_e                   state_q, state_d, op_c;
  logic [CNT_W-1:0]      starve_q;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic [ADDR_WIDTH-1:0] addr_r1_q, addr_r2_q, addr_w_q;
  logic [DATA_WIDTH-1:0] data_w_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data1_q, rsp_data2_q;

  logic                  wb_valid, wb_load, drain_c, starved_c;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data, fwd1_c, fwd2_c;

  assign starved_c = (starve_q >= CNT_W'(STARVE_LIMIT));
  assign wb_load   = WR_VALID && WR_READY;

  regfile_wbuf #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wbuf (
    .clk        (CLK),
    .rst        (RST),
    .load       (wb_load),
    .drain      (drain_c),
    .load_addr  (WR_ADDR),
    .load_data  (WR_DATA),
    .rd_addr1   (RD_ADDR1),
    .rd_addr2   (RD_ADDR2),
    .rf_data1   (RF_DATA_R1),
    .rf_data2   (RF_DATA_R2),
    .valid      (wb_valid),
    .addr       (wb_addr),
    .data       (wb_data),
    .fwd_data1_c(fwd1_c),
    .fwd_data2_c(fwd2_c)
  );

  // Per-cycle op selection; nothing is issued while reset is held.
  always_comb begin
    op_c     = ST_IDLE;
    state_d  = state_q;
    RD_READY = 1'b0;
    WR_READY = 1'b0;
    if (!RST) begin
      if (state_q == ST_INIT) begin
        op_c = ST_INIT;
        if (init_addr_q == LAST_ADDR) state_d = ST_IDLE;
      end else begin
        if (RD_VALID && !starved_c) op_c = ST_READ;
        else if (wb_valid)          op_c = ST_WRITE;
        state_d  = op_c;
        RD_READY = !starved_c;
        WR_READY = !wb_valid || (op_c == ST_WRITE);
      end
    end
  end

  assign drain_c = (op_c == ST_WRITE);

  // Register-file port drive; idle cycles replay the held values.
  always_comb begin
    RF_READ    = (op_c == ST_READ);
    RF_WRITE   = (op_c == ST_WRITE) || (op_c == ST_INIT);
    RF_ADDR_R1 = addr_r1_q;
    RF_ADDR_R2 = addr_r2_q;
    RF_ADDR_W  = addr_w_q;
    RF_DATA_W  = data_w_q;
    if (op_c == ST_READ) begin
      RF_ADDR_R1 = RD_ADDR1;
      RF_ADDR_R2 = RD_ADDR2;
    end
    if (op_c == ST_INIT) begin
      RF_ADDR_W = init_addr_q;
      RF_DATA_W = '0;
    end else if (op_c == ST_WRITE) begin
      RF_ADDR_W = wb_addr;
      RF_DATA_W = wb_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
      starve_q    <= '0;
      init_addr_q <= '0;
      addr_r1_q   <= '0;
      addr_r2_q   <= '0;
      addr_w_q    <= '0;
      data_w_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data1_q <= '0;
      rsp_data2_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_r1_q   <= RF_ADDR_R1;
      addr_r2_q   <= RF_ADDR_R2;
      addr_w_q    <= RF_ADDR_W;
      data_w_q    <= RF_DATA_W;
      rsp_valid_q <= (op_c == ST_READ);
      if (op_c == ST_INIT) init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
      if (!wb_valid || drain_c)                starve_q <= '0;
      else if (op_c == ST_READ && !starved_c)  starve_q <= starve_q + CNT_W'(1);
      if (op_c == ST_READ) begin
        rsp_data1_q <= fwd1_c;
        rsp_data2_q <= fwd2_c;
      end
    end
  end

  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA1 = rsp_data1_q;
  assign RSP_DATA2 = rsp_data2_q;

endmodule

// File: tb/tb_regfile_access_seq.sv
// Scoreboard bench for regfile_access_seq: instance 1 clears on reset,
// instance 0 does not; each has its own register-file model.
module tb_regfile_access_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct packed {
    logic [0:0]    k;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst [2];
  logic          rd_valid [2], rd_ready [2], rsp_valid [2];
  logic          wr_valid [2], wr_ready [2], rf_read [2], rf_write [2];
  logic [AW-1:0] rd_addr1 [2], rd_addr2 [2], wr_addr [2];
  logic [AW-1:0] rf_addr_r1 [2], rf_addr_r2 [2], rf_addr_w [2];
  logic [DW-1:0] rsp_data1 [2], rsp_data2 [2], wr_data [2];
  logic [DW-1:0] rf_data_w [2], rf_data_r1 [2], rf_data_r2 [2];

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [DW-1:0] mem [2**AW];

    regfile_access_seq #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4), .INIT_CLEAR(k)
    ) u_dut (
      .CLK(clk), .RST(rst[k]),
      .RD_VALID(rd_valid[k]), .RD_READY(rd_ready[k]),
      .RD_ADDR1(rd_addr1[k]), .RD_ADDR2(rd_addr2[k]),
      .RSP_VALID(rsp_valid[k]), .RSP_DATA1(rsp_data1[k]), .RSP_DATA2(rsp_data2[k]),
      .WR_VALID(wr_valid[k]), .WR_READY(wr_ready[k]),
      .WR_ADDR(wr_addr[k]), .WR_DATA(wr_data[k]),
      .RF_ADDR_R1(rf_addr_r1[k]), .RF_ADDR_R2(rf_addr_r2[k]), .RF_ADDR_W(rf_addr_w[k]),
      .RF_DATA_W(rf_data_w[k]), .RF_READ(rf_read[k]), .RF_WRITE(rf_write[k]),
      .RF_DATA_R1(rf_data_r1[k]), .RF_DATA_R2(rf_data_r2[k])
    );

    always @(posedge clk) if (rf_write[k]) mem[rf_addr_w[k]] <= rf_data_w[k];
    assign rf_data_r1[k] = mem[rf_addr_r1[k]];
    assign rf_data_r2[k] = mem[rf_addr_r2[k]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    wr_valid[k] = 1'b1; wr_addr[k] = a; wr_data[k] = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = wr_ready[k];
      cyc();
    end
    wr_valid[k] = 1'b0;
    check("wr_accept", 64'(ok), 64'd1);
  endtask

  task automatic do_read(input int k, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    e.k = 1'(k); e.d1 = e1; e.d2 = e2;
    sb.push_back(e);
    rd_valid[k] = 1'b1; rd_addr1[k] = a1; rd_addr2[k] = a2;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = rd_ready[k];
      cyc();
    end
    rd_valid[k] = 1'b0;
    check("rd_accept", 64'(ok), 64'd1);
    if (ok) check("rsp_latency", 64'(rsp_valid[k]), 64'd1);
  endtask

  // Response monitor and read/write exclusivity watch.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rf_read[k] && rf_write[k]) begin
        n_fail++;
        $display("FAIL rd_wr_exclusive dut%0d: got RF_READ=1 RF_WRITE=1, expected not both", k);
      end
      if (rsp_valid[k]) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected dut%0d: got %h/%h, expected no response",
                   k, rsp_data1[k], rsp_data2[k]);
        end else begin
          e = sb.pop_front();
          check("rsp_port", 64'(k), 64'(e.k));
          check("rsp_data1", 64'(rsp_data1[k]), 64'(e.d1));
          check("rsp_data2", 64'(rsp_data2[k]), 64'(e.d2));
        end
      end
    end
  end

  initial begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; rd_valid[k] = 1'b0; wr_valid[k] = 1'b0;
      rd_addr1[k] = '0; rd_addr2[k] = '0; wr_addr[k] = '0; wr_data[k] = '0;
    end
    cyc();
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Post-reset clear sweep on instance 1; instance 0 idles ready.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("init_op", 64'({rf_write[1], rf_read[1], rd_ready[1], wr_ready[1], rf_addr_w[1], rf_data_w[1]}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 5'(i), 32'd0}));
      if (i == 0) begin
        check("noinit_ready", 64'({rd_ready[0], wr_ready[0], rsp_valid[0]}), 64'(3'b110));
        check("rst_outputs", 64'({rsp_data1[1], rf_addr_r1[1], rf_addr_r2[1]}), 64'd0);
      end
    end
    @(negedge clk);
    check("init_done", 64'({rf_write[1], rd_ready[1], wr_ready[1]}), 64'(3'b011));
    cyc();

    // Write then read: forwarded first, then from the register file.
    do_write(1, 5'd5, 32'hDEADBEEF);
    do_read(1, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
    cyc();
    do_read(1, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0);
    cyc();

    // Read stream starving a buffered write until the limit forces a drain.
    do_write(1, 5'd7, 32'h12345678);
    rd_valid[1] = 1'b1; rd_addr1[1] = 5'd7; rd_addr2[1] = 5'd7;
    e.k = 1'b1; e.d1 = 32'h12345678; e.d2 = 32'h12345678;
    repeat (4) sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fwd_read", 64'({rd_ready[1], rf_read[1]}), 64'(2'b11));
      cyc();
    end
    @(negedge clk);
    check("starve_drain", 64'({rd_ready[1], rf_write[1], rf_addr_w[1], rf_data_w[1]}),
          64'({1'b0, 1'b1, 5'd7, 32'h12345678}));
    cyc();
    rd_valid[1] = 1'b0;
    @(negedge clk);
    check("idle_hold", 64'({rf_write[1], rsp_valid[1], rf_addr_w[1], rsp_data1[1]}),
          64'({1'b0, 1'b0, 5'd7, 32'h12345678}));
    cyc();

    // Same-cycle read and write to r9: read sees the old value.
    do_write(1, 5'd9, 32'h1);
    cyc();
    cyc();
    wr_valid[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h2;
    rd_valid[1] = 1'b1; rd_addr1[1] = 5'd9; rd_addr2[1] = 5'd9;
    e.k = 1'b1; e.d1 = 32'h1; e.d2 = 32'h1;
    sb.push_back(e);
    @(negedge clk);
    check("same_cycle_ready", 64'({rd_ready[1], wr_ready[1]}), 64'(2'b11));
    cyc();
    wr_valid[1] = 1'b0; rd_valid[1] = 1'b0;
    do_read(1, 5'd9, 5'd9, 32'h2, 32'h2);
    cyc();
    do_read(1, 5'd9, 5'd9, 32'h2, 32'h2);
    cyc();

    // Reset on instance 0 with a write still buffered: it must be dropped.
    do_write(0, 5'd3, 32'hAAAA5555);
    cyc();
    cyc();
    do_read(0, 5'd3, 5'd3, 32'hAAAA5555, 32'hAAAA5555);
    wr_valid[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'hBBBB0000;
    @(negedge clk);
    check("wr_accept_pre_rst", 64'(wr_ready[0]), 64'd1);
    cyc();
    wr_valid[0] = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    check("rst_no_write", 64'(rf_write[0]), 64'd0);
    cyc();
    rst[0] = 1'b0;
    @(negedge clk);
    check("rst_state", 64'({rd_ready[0], wr_ready[0], rsp_valid[0], rf_read[0], rf_write[0]}),
          64'(5'b11000));
    check("rst_clears", 64'({rsp_data1[0], rf_addr_w[0]}), 64'd0);
    check("rst_clears_w", 64'(rf_data_w[0]), 64'd0);
    cyc();
    do_read(0, 5'd3, 5'd3, 32'hAAAA5555, 32'hAAAA5555);

    repeat (3) cyc();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_access_seq.md
REGFILE_ACCESS_SEQ -- requirements
Module: regfile_access_seq

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 32: data word width.
- ADDR_WIDTH, default 5: register address width (2^ADDR_WIDTH registers).
- STARVE_LIMIT, default 4: consecutive read-won cycles a buffered write may wait.
- INIT_CLEAR, default 1: 1 = zero-fill all registers after reset.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK  in  1  sole clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- RD_VALID  in  1  read request valid.
- RD_READY  out  1  read request accepted when high with RD_VALID.
- RD_ADDR1, RD_ADDR2  in  ADDR_WIDTH  operand addresses.
- RSP_VALID  out  1  one-cycle pulse: read response valid (no backpressure).
- RSP_DATA1, RSP_DATA2  out  DATA_WIDTH  read response data.
- WR_VALID  in  1  write request valid.
- WR_READY  out  1  write request accepted when high with WR_VALID.
- WR_ADDR  in  ADDR_WIDTH  write address.
- WR_DATA  in  DATA_WIDTH  write data.
- RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W  out  ADDR_WIDTH  register-file addresses.
- RF_DATA_W  out  DATA_WIDTH  register-file write data.
- RF_READ, RF_WRITE  out  1  register-file read / write strobes.
- RF_DATA_R1, RF_DATA_R2  in  DATA_WIDTH  register-file read data, valid in the cycle RF_READ=1.
REQ-003 Clock and reset are CLK and RST: one clock; reset is synchronous and active-high.

Function
REQ-004 RF_READ and RF_WRITE SHALL never be high in the same cycle; each cycle the FSM issues exactly one op: IDLE, READ, WRITE or INIT.
REQ-005 Write path SHALL be a one-entry buffer (wb_valid, wb_addr, wb_data); WR_READY = !wb_valid, or the buffer drains this cycle; it is not combinationally dependent on WR_VALID.
REQ-006 Read path SHALL be unbuffered: an accepted read drives RF_READ=1 and RF_ADDR_R1/R2 = RD_ADDR1/2 in the same cycle, samples RF_DATA_R* at that edge, and pulses RSP_VALID the next cycle (latency 1).
REQ-007 Arbitration per cycle:
- RD_VALID && starve_cnt < STARVE_LIMIT -> READ.
- Otherwise, wb_valid -> WRITE (drain buffer).
- Otherwise -> IDLE.
REQ-008 starve_cnt SHALL increment on each READ cycle while wb_valid, clear on drain or when wb_valid=0, and saturate at STARVE_LIMIT; while at the limit, RD_READY=0.
REQ-009 Forwarding: if wb_valid and RD_ADDRn == wb_addr on a READ cycle, RSP_DATAn SHALL return wb_data instead of RF_DATA_Rn, independently per port.
REQ-010 A read and a write accepted in the same cycle SHALL order read-before-write: the read sees the old value, and the new write is not forwarded to it.
REQ-011 A write accepted while the buffer drains SHALL occupy the buffer next cycle with no bubble.
REQ-012 RSP_DATA1/2 SHALL hold their last value when RSP_VALID=0.
REQ-013 In IDLE cycles RF_* address and data outputs SHALL hold their previous values.

Reset
REQ-014 RST high at a rising edge SHALL clear:
- wb_valid, starve_cnt.
- RSP_VALID, RSP_DATA1/2 (to 0).
- RF_READ, RF_WRITE.
- All RF address and data outputs (to 0).
A buffered write is discarded, not written.
REQ-015 After RST deasserts, with INIT_CLEAR=1 the FSM SHALL enter INIT: RF_WRITE=1, RF_DATA_W=0, RF_ADDR_W counts 0..2^ADDR_WIDTH-1, one register per cycle. RD_READY=WR_READY=0 throughout INIT; then IDLE.
REQ-016 With INIT_CLEAR=0 the FSM SHALL enter IDLE directly, with both READY outputs high the first cycle after RST deasserts.
REQ-017 RST asserted during INIT SHALL restart INIT from address 0.

Structure
REQ-018 FSM state encoding (IDLE, READ, WRITE, INIT) and default width constants SHALL live in the shared project definitions package.
REQ-019 The write buffer with forwarding compare SHALL be one sub-module, regfile_wbuf; the arbiter/FSM stays in the top.

Verification
REQ-020 The bench SHALL cover:
- INIT_CLEAR=1, RST one cycle -> 32 consecutive RF_WRITE cycles, addresses 0..31, data 0; READY outputs rise on cycle 33.
- Write r5=0xDEADBEEF, then read RD_ADDR1=5, RD_ADDR2=0 -> RSP_VALID one cycle after acceptance, RSP_DATA1=0xDEADBEEF, RSP_DATA2=0.
- Buffer r7=0x12345678, RD_VALID held with RD_ADDR1=RD_ADDR2=7 -> first 4 responses 0x12345678 (forwarded); cycle 5 RD_READY=0, RF_WRITE=1 with RF_ADDR_W=7.
- Same-cycle read r9 (holds 0x1) and write r9=0x2 -> response 0x1; next read -> 0x2.
- RST asserted with wb_valid=1 -> no RF_WRITE of buffered data; the buffered address still reads its pre-write value after INIT_CLEAR=0 restart.
- Continuous assertion across all tests: never RF_READ && RF_WRITE.
